// File: rtl/int_byte_arb_pkg.sv
// Shared types and narrowing helpers for the int-to-byte round-robin arbiter.
package int_byte_arb_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Clamp a signed int into the signed byte range.
    function automatic byte narrow_sat(input int v);
        if (v > 127) begin
            return 8'sh7F;
        end else if (v < -128) begin
            return 8'sh80;
        end else begin
            return 8'(v);
        end
    endfunction

    function automatic byte narrow_trunc(input int v);
        return 8'(v);
    endfunction

endpackage

// File: rtl/int_byte_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first valid index at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW:0] sum;
    logic        found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        // ptr < N, so a single conditional subtract keeps ptr+k inside [0, N).
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!found && valid[sum[IW-1:0]]) begin
                found = 1'b1;
                idx   = sum[IW-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/int_byte_rr_arbiter.sv
// Round-robin arbiter sharing one int-to-byte narrowing stage across NREQ
// requesters, with a single-entry valid/ready output register.
module int_byte_rr_arbiter
    import int_byte_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter bit          SAT  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  int                      req_data [NREQ],
    output logic [NREQ-1:0]         req_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic signed [7:0]       out_data,
    output logic [$clog2(NREQ)-1:0] out_src,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        grant_cnt
);

    localparam int unsigned SW = $clog2(NREQ);

    state_e                state_q, state_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [7:0]     data_q, data_d;
    logic [SW-1:0]         src_q, src_d;
    logic                  pick_any;
    logic [SW-1:0]         pick_idx;
    logic                  can_load;

    rr_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    // Next state, grant and load; flush and reset block any accept.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        src_d     = src_q;
        req_ready = '0;
        can_load  = (state_q == EMPTY) || out_ready;

        if (rst || flush) begin
            state_d = EMPTY;
        end else if (can_load && pick_any) begin
            req_ready[pick_idx] = 1'b1;
            data_d  = SAT ? narrow_sat(req_data[pick_idx])
                          : narrow_trunc(req_data[pick_idx]);
            src_d   = pick_idx;
            ptr_d   = (pick_idx == SW'(NREQ-1)) ? '0 : pick_idx + SW'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_int_byte_rr_arbiter.sv
// Scoreboard bench: a cycle model predicts grants and narrowed results for
// a truncating and a saturating instance driven with identical inputs.
module tb_int_byte_rr_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid;
    int                req_data [4];
    logic              flush;
    logic              out_ready;

    logic [3:0]        req_ready, req_ready_s;
    logic              out_valid, out_valid_s;
    logic signed [7:0] out_data, out_data_s;
    logic [1:0]        out_src, out_src_s;
    logic [15:0]       grant_cnt, grant_cnt_s;

    typedef struct {
        logic [1:0]        src;
        logic signed [7:0] dt;
        logic signed [7:0] ds;
    } exp_t;

    exp_t        q[$];
    bit          m_full;
    int          m_ptr;
    logic [15:0] m_cnt;
    int          checks = 0;
    int          failures = 0;

    int_byte_rr_arbiter #(.NREQ(4), .SAT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .grant_cnt(grant_cnt)
    );

    int_byte_rr_arbiter #(.NREQ(4), .SAT(1'b1)) u_dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_s), .flush(flush), .out_valid(out_valid_s),
        .out_data(out_data_s), .out_src(out_src_s), .out_ready(out_ready),
        .grant_cnt(grant_cnt_s)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] m_trunc(input int v);
        logic [31:0] t;
        t = v;
        return t[7:0];
    endfunction

    function automatic logic signed [7:0] m_sat(input int v);
        if (v > 127)  return 8'sh7F;
        if (v < -128) return 8'sh80;
        return m_trunc(v);
    endfunction

    // One clock: predict grant, score the output register, advance the model.
    task automatic step();
        logic [3:0] exp_rdy;
        bit         acc;
        bit         consume;
        int         w;
        exp_t       e;
        #1;
        exp_rdy = '0;
        acc     = 1'b0;
        w       = 0;
        if (!rst && !flush && (!m_full || out_ready)) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!acc && req_valid[c]) begin
                    acc = 1'b1;
                    w   = c;
                end
            end
            if (acc) exp_rdy[w] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, exp_rdy, $time);
        end
        checks++;
        if (req_ready_s !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready_sat got=%b exp=%b t=%0t", req_ready_s, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== m_full || out_valid_s !== m_full) begin
            failures++;
            $display("FAIL out_valid got=%b/%b exp=%b t=%0t", out_valid, out_valid_s, m_full, $time);
        end
        checks++;
        if (grant_cnt !== m_cnt) begin
            failures++;
            $display("FAIL grant_cnt got=%h exp=%h t=%0t", grant_cnt, m_cnt, $time);
        end
        if (m_full) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else if (out_src !== q[0].src || out_data !== q[0].dt || out_data_s !== q[0].ds) begin
                failures++;
                $display("FAIL result got src=%0d trunc=%0d sat=%0d exp src=%0d trunc=%0d sat=%0d t=%0t",
                         out_src, out_data, out_data_s, q[0].src, q[0].dt, q[0].ds, $time);
            end
        end
        consume = !rst && !flush && m_full && out_ready;
        if (rst) begin
            q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
            m_cnt  = '0;
        end else if (flush) begin
            q.delete();
            m_full = 1'b0;
        end else begin
            if (consume && q.size() > 0) e = q.pop_front();
            if (acc) begin
                e.src = 2'(w);
                e.dt  = m_trunc(req_data[w]);
                e.ds  = m_sat(req_data[w]);
                q.push_back(e);
                m_full = 1'b1;
                m_ptr  = (w + 1) % 4;
                m_cnt  = m_cnt + 16'd1;
            end else if (consume) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_src !== 2'd0 || grant_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_values got v=%b d=%0d s=%0d c=%h exp 0", out_valid, out_data, out_src, grant_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) req_data[k] = int'($urandom);
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'((i - 1) % 4)) begin
                failures++;
                $display("FAIL rr_order step=%0d got v=%b src=%0d exp src=%0d", i, out_valid, out_src, (i - 1) % 4);
            end
            if (i == 4) begin
                checks++;
                if (grant_cnt !== 16'd4) begin
                    failures++;
                    $display("FAIL rr_grant_cnt got=%0d exp=4", grant_cnt);
                end
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_sparse();
        int seq [3] = '{1, 3, 1};
        do_reset();
        req_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_src !== 2'(seq[i])) begin
                failures++;
                $display("FAIL sparse_order idx=%0d got=%0d exp=%0d", i, out_src, seq[i]);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_narrow();
        int                vin [5] = '{300, -1000, -5, 200, 127};
        logic signed [7:0] et  [5] = '{8'sd44, 8'sd24, -8'sd5, -8'sd56, 8'sd127};
        logic signed [7:0] es  [5] = '{8'sd127, 8'sh80, -8'sd5, 8'sd127, 8'sd127};
        req_valid = 4'b0001; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_data[0] = vin[i];
            step();
            checks++;
            if (out_data !== et[i] || out_data_s !== es[i]) begin
                failures++;
                $display("FAIL narrow in=%0d got trunc=%0d sat=%0d exp trunc=%0d sat=%0d",
                         vin[i], out_data, out_data_s, et[i], es[i]);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt0;
        logic [3:0]  exp_rdy;
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) req_data[k] = int'($urandom);
        step();
        cnt0 = m_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || grant_cnt !== cnt0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%b cnt=%0d exp v=1 cnt=%0d", i, out_valid, grant_cnt, cnt0);
            end
        end
        out_ready = 1'b1;
        #1;
        exp_rdy = 4'b0001 << m_ptr;
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL release_grant got=%b exp=%b", req_ready, exp_rdy);
        end
        step();
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || grant_cnt !== 16'd1) begin
            failures++;
            $display("FAIL flush_empty got v=%b cnt=%0d exp v=0 cnt=1", out_valid, grant_cnt);
        end
        step();
        checks++;
        if (out_src !== 2'd1 || grant_cnt !== 16'd2) begin
            failures++;
            $display("FAIL flush_ptr got src=%0d cnt=%0d exp src=1 cnt=2", out_src, grant_cnt);
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        repeat (65535) step();
        checks++;
        if (grant_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_full got=%h exp=ffff", grant_cnt);
        end
        step();
        checks++;
        if (grant_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL cnt_wrap got=%h exp=0000", grant_cnt);
        end
        step();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_src !== 2'd0 || grant_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset got v=%b d=%0d s=%0d c=%h exp 0", out_valid, out_data, out_src, grant_cnt);
        end
        req_valid = 4'b0110;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            failures++;
            $display("FAIL midreset_first got v=%b src=%0d exp v=1 src=1", out_valid, out_src);
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = '0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) req_data[k] = 0;
        m_full = 1'b0; m_ptr = 0; m_cnt = '0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_sparse();
        test_narrow();
        test_backpressure();
        test_flush();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
